clkdiv_release_ctrl: RTL and testbench

- Sequencer that drives the reset, release and edge-clock-stop controls of a CLKDIVB-style divider, i.e. the controlling end of the divider's RST/RELEASE interface.
- It waits for a filtered PLL lock, holds the divider in reset, then stops the edge clock. It then releases the divider so the divided clocks start phase-aligned, and finally reports READY.
- It sits between the PLL and the ECLKSYNC/CLKDIVB pair in the DDR gearing clock path.

---
 rtl/clkdiv_release_ctrl.sv | 156 +++++++++++++++
 tb/tb_clkdiv_release_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_release_ctrl.sv
// Reset/release sequencer for a CLKDIVB-style divider: filters PLL lock, holds the divider in
// reset, stops the edge clock, then releases so the divided clocks start phase-aligned.
module clkdiv_release_ctrl #(
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned RST_CYCLES  = 8,
  parameter int unsigned RELEASE_DLY = 4,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic       CLKI,
  input  logic       RST,
  input  logic       LOCK,
  input  logic       RESTART,
  output logic       DIV_RST,
  output logic       DIV_RELEASE,
  output logic       ECLK_STOP,
  output logic       READY,
  output logic [2:0] STATE
);

  localparam int unsigned MaxCount =
      (LOCK_CYCLES > RST_CYCLES) ?
      ((LOCK_CYCLES > RELEASE_DLY) ? LOCK_CYCLES : RELEASE_DLY) :
      ((RST_CYCLES > RELEASE_DLY) ? RST_CYCLES : RELEASE_DLY);

  if (LOCK_CYCLES == 0 || RST_CYCLES == 0 || RELEASE_DLY == 0) begin : g_bad_count
    $error("clkdiv_release_ctrl: LOCK_CYCLES, RST_CYCLES and RELEASE_DLY must all be >= 1");
  end

  if (CNT_WIDTH == 0 || ((MaxCount - 1) >> CNT_WIDTH) != 0) begin : g_bad_width
    $error("clkdiv_release_ctrl: CNT_WIDTH too small for the largest count parameter");
  end

  localparam logic [CNT_WIDTH-1:0] LockLast = CNT_WIDTH'(LOCK_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RstLast  = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DlyLast  = CNT_WIDTH'(RELEASE_DLY - 1);

  typedef enum logic [2:0] {
    StWaitLock    = 3'd0,
    StRstHold     = 3'd1,
    StStopHold    = 3'd2,
    StReleaseWait = 3'd3,
    StReady       = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   div_rst_q, div_rst_d;
  logic                   div_release_q, div_release_d;
  logic                   eclk_stop_q, eclk_stop_d;
  logic                   ready_q, ready_d;

  // Next-state logic. Priority: lock loss, then RESTART, then counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      StWaitLock: begin
        if (!LOCK) begin
          cnt_d = '0;
        end else if (cnt_q == LockLast) begin
          state_d = StRstHold;
          cnt_d   = '0;
        end
      end
      StRstHold: begin
        if (!LOCK) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == RstLast) begin
          state_d = StStopHold;
          cnt_d   = '0;
        end
      end
      StStopHold: begin
        if (!LOCK) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == DlyLast) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end
      end
      StReleaseWait: begin
        if (!LOCK) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == DlyLast) begin
          state_d = StReady;
          cnt_d   = '0;
        end
      end
      StReady: begin
        cnt_d = '0;
        if (!LOCK) begin
          state_d = StWaitLock;
        end else if (RESTART) begin
          state_d = StRstHold;
        end
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as STATE.
  always_comb begin
    div_rst_d     = 1'b1;
    div_release_d = 1'b0;
    eclk_stop_d   = 1'b1;
    ready_d       = 1'b0;
    case (state_d)
      StStopHold: begin
        div_rst_d = 1'b0;
      end
      StReleaseWait: begin
        div_rst_d     = 1'b0;
        div_release_d = 1'b1;
        eclk_stop_d   = 1'b0;
      end
      StReady: begin
        div_rst_d     = 1'b0;
        div_release_d = 1'b1;
        eclk_stop_d   = 1'b0;
        ready_d       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLKI or posedge RST) begin
    if (RST) begin
      state_q       <= StWaitLock;
      cnt_q         <= '0;
      div_rst_q     <= 1'b1;
      div_release_q <= 1'b0;
      eclk_stop_q   <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_rst_q     <= div_rst_d;
      div_release_q <= div_release_d;
      eclk_stop_q   <= eclk_stop_d;
      ready_q       <= ready_d;
    end
  end

  assign DIV_RST     = div_rst_q;
  assign DIV_RELEASE = div_release_q;
  assign ECLK_STOP   = eclk_stop_q;
  assign READY       = ready_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_clkdiv_release_ctrl.sv
// Bench for clkdiv_release_ctrl: directed stimulus, a position-in-sequence model checked every
// cycle, plus hand-computed literal expectations at the key edges.
module tb_clkdiv_release_ctrl;

  localparam int unsigned LockN  = 16;
  localparam int unsigned RstN   = 8;
  localparam int unsigned DlyN   = 4;
  localparam int unsigned SeqLen = RstN + 2 * DlyN;

  logic       CLKI = 1'b0;
  logic       RST = 1'b0;
  logic       LOCK = 1'b0;
  logic       RESTART = 1'b0;
  logic       DIV_RST, DIV_RELEASE, ECLK_STOP, READY;
  logic [2:0] STATE;

  int n_cmp = 0;
  int n_bad = 0;

  clkdiv_release_ctrl #(
    .LOCK_CYCLES(LockN),
    .RST_CYCLES (RstN),
    .RELEASE_DLY(DlyN),
    .CNT_WIDTH  (8)
  ) dut (
    .CLKI       (CLKI),
    .RST        (RST),
    .LOCK       (LOCK),
    .RESTART    (RESTART),
    .DIV_RST    (DIV_RST),
    .DIV_RELEASE(DIV_RELEASE),
    .ECLK_STOP  (ECLK_STOP),
    .READY      (READY),
    .STATE      (STATE)
  );

  always #5 CLKI = ~CLKI;

  // Model: either filtering lock (run = consecutive lock edges) or somewhere in the
  // release sequence (pos = edges since the sequence started, saturating at SeqLen).
  typedef struct packed {
    logic        waiting;
    int unsigned run;
    int unsigned pos;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mstep(input mdl_t c, input logic lk, input logic rs);
    mdl_t n;
    n = c;
    if (c.waiting) begin
      if (!lk) n.run = 0;
      else if (c.run + 1 == LockN) begin
        n.waiting = 1'b0;
        n.run     = 0;
        n.pos     = 0;
      end else n.run = c.run + 1;
    end else if (!lk) begin
      n.waiting = 1'b1;
      n.run     = 0;
      n.pos     = 0;
    end else if (c.pos >= SeqLen && rs) begin
      n.pos = 0;
    end else if (c.pos < SeqLen) begin
      n.pos = c.pos + 1;
    end
    return n;
  endfunction

  function automatic logic [2:0] exp_state(input mdl_t c);
    if (c.waiting) return 3'd0;
    if (c.pos < RstN) return 3'd1;
    if (c.pos < RstN + DlyN) return 3'd2;
    if (c.pos < SeqLen) return 3'd3;
    return 3'd4;
  endfunction

  // {DIV_RST, DIV_RELEASE, ECLK_STOP, READY} per state
  function automatic logic [3:0] exp_outs(input logic [2:0] s);
    case (s)
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0100;
      3'd4:    return 4'b0101;
      default: return 4'b1010;
    endcase
  endfunction

  always @(posedge CLKI or posedge RST) begin
    if (RST) m <= '{waiting: 1'b1, run: 0, pos: 0};
    else     m <= mstep(m, LOCK, RESTART);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLKI) begin
    chk("model_state", {29'd0, STATE}, {29'd0, exp_state(m)});
    chk("model_outs", {28'd0, DIV_RST, DIV_RELEASE, ECLK_STOP, READY},
        {28'd0, exp_outs(exp_state(m))});
    chk("inv_release_with_rst", {31'd0, DIV_RELEASE & DIV_RST}, 32'd0);
  end

  task automatic step(input logic lk, input logic rs);
    LOCK    = lk;
    RESTART = rs;
    @(posedge CLKI);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_state"}, {29'd0, STATE}, 32'd0);
    chk({tag, "_div_rst"}, {31'd0, DIV_RST}, 32'd1);
    chk({tag, "_div_release"}, {31'd0, DIV_RELEASE}, 32'd0);
    chk({tag, "_eclk_stop"}, {31'd0, ECLK_STOP}, 32'd1);
    chk({tag, "_ready"}, {31'd0, READY}, 32'd0);
  endtask

  initial begin
    #2 RST = 1'b1;
    #1 chk_reset_outs("por");
    @(posedge CLKI);
    #1 RST = 1'b0;

    // Full sequence from first LOCK edge
    for (int e = 1; e <= 32; e++) begin
      step(1'b1, 1'b0);
      if (e == 15) chk("t1_e15_state", {29'd0, STATE}, 32'd0);
      if (e == 16) chk("t1_e16_state", {29'd0, STATE}, 32'd1);
      if (e == 23) chk("t1_e23_div_rst", {31'd0, DIV_RST}, 32'd1);
      if (e == 24) begin
        chk("t1_e24_div_rst", {31'd0, DIV_RST}, 32'd0);
        chk("t1_e24_state", {29'd0, STATE}, 32'd2);
      end
      if (e == 27) chk("t1_e27_release", {31'd0, DIV_RELEASE}, 32'd0);
      if (e == 28) begin
        chk("t1_e28_state", {29'd0, STATE}, 32'd3);
        chk("t1_e28_release", {31'd0, DIV_RELEASE}, 32'd1);
        chk("t1_e28_eclk_stop", {31'd0, ECLK_STOP}, 32'd0);
      end
      if (e == 31) chk("t1_e31_ready", {31'd0, READY}, 32'd0);
      if (e == 32) begin
        chk("t1_e32_ready", {31'd0, READY}, 32'd1);
        chk("t1_e32_state", {29'd0, STATE}, 32'd4);
      end
    end

    // Lock glitch restarts the filter
    step(1'b0, 1'b0);
    chk_reset_outs("t2_lockloss");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("t2_glitch_state", {29'd0, STATE}, 32'd0);
    for (int e = 1; e <= 32; e++) begin
      step(1'b1, 1'b0);
      if (e == 31) chk("t2_e31_ready", {31'd0, READY}, 32'd0);
      if (e == 32) chk("t2_e32_ready", {31'd0, READY}, 32'd1);
    end

    // RESTART in READY, then a second RESTART in RST_HOLD that must be ignored
    step(1'b1, 1'b1);
    chk("t3_restart_state", {29'd0, STATE}, 32'd1);
    chk("t3_restart_ready", {31'd0, READY}, 32'd0);
    step(1'b1, 1'b1);
    chk("t3_restart_in_hold", {29'd0, STATE}, 32'd1);
    for (int e = 3; e <= 17; e++) begin
      step(1'b1, 1'b0);
      if (e == 16) chk("t3_e16_ready", {31'd0, READY}, 32'd0);
      if (e == 17) chk("t3_e17_ready", {31'd0, READY}, 32'd1);
    end

    // LOCK=0 beats RESTART
    step(1'b0, 1'b1);
    chk("t4_prio_state", {29'd0, STATE}, 32'd0);
    chk("t4_prio_ready", {31'd0, READY}, 32'd0);

    // Lock loss during STOP_HOLD
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
    chk("t5_in_stop_hold", {29'd0, STATE}, 32'd2);
    step(1'b0, 1'b0);
    chk_reset_outs("t5_drop");
    for (int e = 1; e <= 32; e++) begin
      step(1'b1, 1'b0);
      if (e == 31) chk("t5_e31_ready", {31'd0, READY}, 32'd0);
      if (e == 32) chk("t5_e32_ready", {31'd0, READY}, 32'd1);
    end

    // Asynchronous reset between edges in RELEASE_WAIT
    step(1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
    chk("t6_in_release_wait", {29'd0, STATE}, 32'd3);
    #2 RST = 1'b1;
    #1 chk_reset_outs("t6_async");
    @(posedge CLKI);
    #1 RST = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      step(1'b1, 1'b0);
      if (e == 32) chk("t6_e32_ready", {31'd0, READY}, 32'd1);
    end

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
